// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: sequences one activation tile into the triangular skew register
// feeding the systolic array.
//
// A tile streams num_rows rows from the activation buffer (1-cycle read latency),
// then holds for N_SIZE cycles while the skew pipeline drains, then pulses done.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         tile request, sampled only in IDLE
//   abort         synchronous abort, returns to IDLE from any busy/done state
//   base_addr     buffer address of row 0, latched on an accepted start
//   num_rows      rows to stream, latched on an accepted start
//   busy          high in FEED and DRAIN
//   done          one-cycle completion pulse
//   aborted       one-cycle pulse the cycle after an abort outside IDLE
//   buf_rd_en     buffer read strobe
//   buf_rd_addr   buffer read address (wraps modulo 2^ADDR_W)
//   feed_valid    buffer data at the skew input is valid (buf_rd_en delayed 1)
//   lane_valid    bit k: skew output lane k is valid (feed_valid delayed k)
module skew_feed_ctrl #(
  parameter int unsigned N_SIZE = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              feed_valid,
  output logic [N_SIZE-1:0] lane_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;
  logic              feed_valid_q;
  logic              aborted_q;
  // pipe_q[k-1] holds feed_valid delayed k cycles, i.e. lane_valid[k].
  logic [N_SIZE-2:0] pipe_q, pipe_d;

  logic accept;
  logic flush;

  assign accept = (state_q == IDLE) && start && !abort;
  assign flush  = (state_q != IDLE) && abort;

  // cnt_q counts rows in FEED and drain cycles in DRAIN; it is zero on entry to each.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (accept) begin
            state_d = (num_rows != '0) ? FEED : DONE;
          end
        end
        FEED: begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == LEN_W'(N_SIZE - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = feed_valid_q;
    for (int k = 1; k < N_SIZE - 1; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      feed_valid_q <= 1'b0;
      pipe_q       <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        base_q <= base_addr;
        len_q  <= num_rows;
      end
      // Abort flushes every in-flight valid so the array sees no partial tile.
      feed_valid_q <= buf_rd_en && !flush;
      pipe_q       <= flush ? '0 : pipe_d;
      aborted_q    <= flush;
    end
  end

  assign buf_rd_en   = (state_q == FEED);
  assign buf_rd_addr = base_q + ADDR_W'(cnt_q);
  assign busy        = (state_q == FEED) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign aborted     = aborted_q;
  assign feed_valid  = feed_valid_q;
  assign lane_valid  = {pipe_q, feed_valid_q};

endmodule

// File: tb/tb_skew_feed_ctrl.sv
module tb_skew_feed_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [9:0]  num_rows = '0;
  logic        busy, done, aborted, buf_rd_en, feed_valid;
  logic [9:0]  buf_rd_addr;
  logic [15:0] lane_valid;

  int checks = 0;
  int errors = 0;

  skew_feed_ctrl #(.N_SIZE(16), .ADDR_W(10), .LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .num_rows(num_rows), .busy(busy), .done(done),
    .aborted(aborted), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .feed_valid(feed_valid), .lane_valid(lane_valid)
  );

  always #5 clk = ~clk;

  // Reference model: one tile described by its start cycle, row count and base.
  // Expected outputs follow directly from the cycle-window rules of the tile.
  int t = 0;
  int m_active = 0;
  int m_t0 = 0;
  int m_r = 0;
  int m_base = 0;
  int m_abt = -100;

  function automatic int m_done_rel();
    return (m_r == 0) ? 1 : m_r + N + 1;
  endfunction

  function automatic bit m_idle();
    return (m_active == 0) || ((t - m_t0) > m_done_rel());
  endfunction

  function automatic logic [30:0] exp_vec();
    int rel;
    logic [15:0] lv;
    logic rd, fv, bz, dn, ab;
    logic [9:0] ad;
    rel = t - m_t0;
    lv = '0; rd = 0; fv = 0; bz = 0; dn = 0; ad = '0;
    if (m_active != 0) begin
      rd = (m_r > 0) && (rel >= 1) && (rel <= m_r);
      if (rd) ad = 10'(m_base + rel - 1);
      fv = (rel >= 2) && (rel <= m_r + 1);
      for (int k = 0; k < N; k++) lv[k] = (rel >= 2 + k) && (rel <= m_r + 1 + k);
      bz = (m_r > 0) && (rel >= 1) && (rel <= m_r + N);
      dn = (rel == m_done_rel());
    end
    ab = (t == m_abt);
    return {bz, dn, ab, rd, ad, fv, lv};
  endfunction

  function automatic logic [30:0] act_vec();
    return {busy, done, aborted, buf_rd_en, (buf_rd_en ? buf_rd_addr : 10'd0),
            feed_valid, lane_valid};
  endfunction

  // Drive inputs for the current cycle, advance the model over the sampling edge,
  // then move to the next cycle (sampled 1 time unit after the edge).
  task automatic step(input logic s, input logic a, input int b, input int r);
    start = s; abort = a; base_addr = 10'(b); num_rows = 10'(r);
    if (!m_idle() && a) begin
      m_active = 0;
      m_abt = t + 1;
    end else if (m_idle() && s && !a) begin
      m_active = 1; m_t0 = t; m_r = r; m_base = b;
    end else if (m_idle()) begin
      m_active = 0;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic test_reset();
    logic [30:0] a;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; t++;
      a = act_vec();
      checks++;
      if (a !== 31'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h required 0", t, a);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h required %h", t, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    int s, dcnt, drel, bcnt, l15_first, l15_last;
    s = t; dcnt = 0; drel = -1; bcnt = 0; l15_first = -1; l15_last = -1;
    step(1, 0, 'h010, 4);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h required %h", t - s, act_vec(), exp_vec());
      end
      if (done) begin dcnt++; drel = t - s; end
      if (busy) bcnt++;
      if (lane_valid[15]) begin
        if (l15_first < 0) l15_first = t - s;
        l15_last = t - s;
      end
      step(0, 0, 0, 0);
    end
    checks++;
    if (dcnt !== 1 || drel !== 21) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses at %0d required 1 at 21", dcnt, drel);
    end
    checks++;
    if (bcnt !== 20) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d required 20", bcnt);
    end
    checks++;
    if (l15_first !== 17 || l15_last !== 20) begin
      errors++;
      $display("FAIL basic_lane15: got %0d..%0d required 17..20", l15_first, l15_last);
    end
  endtask

  task automatic test_zero_rows();
    int s, rd_seen, bz_seen, drel;
    s = t; rd_seen = 0; bz_seen = 0; drel = -1;
    step(1, 0, 'h123, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL zero_rows cycle %0d: got %h required %h", t - s, act_vec(), exp_vec());
      end
      if (buf_rd_en) rd_seen++;
      if (busy) bz_seen++;
      if (done) drel = t - s;
      step(0, 0, 0, 0);
    end
    checks++;
    if (rd_seen !== 0 || bz_seen !== 0 || drel !== 1) begin
      errors++;
      $display("FAIL zero_rows_summary: got rd=%0d busy=%0d done@%0d required 0 0 1",
               rd_seen, bz_seen, drel);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] got [4];
    logic [9:0] want [4];
    int n;
    want[0] = 10'h3FE; want[1] = 10'h3FF; want[2] = 10'h000; want[3] = 10'h001;
    n = 0;
    step(1, 0, 'h3FE, 4);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap cycle %0d: got %h required %h", t, act_vec(), exp_vec());
      end
      if (buf_rd_en && n < 4) begin got[n] = buf_rd_addr; n++; end
      step(0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= n || got[i] !== want[i]) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got %h required %h", i, (i < n) ? got[i] : 10'hx, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dcnt;
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      step((i < 39) ? 1'b1 : 1'b0, 0, 'h040, 2);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h required %h", i + 1, act_vec(), exp_vec());
      end
      if (done) dcnt++;
    end
    checks++;
    if (dcnt !== 2) begin
      errors++;
      $display("FAIL back_to_back_dones: got %0d required 2", dcnt);
    end
  endtask

  task automatic test_abort();
    int dcnt;
    dcnt = 0;
    step(1, 0, 'h200, 8);
    for (int i = 1; i < 40; i++) begin
      step((i == 7) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0, 'h210, 8);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL abort cycle %0d: got %h required %h", i + 1, act_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if ({aborted, buf_rd_en, feed_valid, lane_valid, done} !== {3'b100, 16'h0, 1'b0}) begin
          errors++;
          $display("FAIL abort_flush: got ab=%b rd=%b fv=%b lv=%h dn=%b required 1 0 0 0000 0",
                   aborted, buf_rd_en, feed_valid, lane_valid, done);
        end
      end
      if (done) dcnt++;
    end
    checks++;
    if (dcnt !== 1) begin
      errors++;
      $display("FAIL abort_dones: got %0d required 1", dcnt);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 'h055, 8);
    for (int i = 1; i < 10; i++) step(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act_vec() !== 31'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", act_vec());
    end
    m_active = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; t++;
      checks++;
      if (act_vec() !== 31'd0) begin
        errors++;
        $display("FAIL async_reset_hold: got %h required 0", act_vec());
      end
    end
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 'h0F0, 3);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL after_reset cycle %0d: got %h required %h", i, act_vec(), exp_vec());
      end
      step(0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    int dcnt;
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 20)));
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h required %h", t, act_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0);
    // Largest row count must complete without the row counter overflowing.
    dcnt = 0;
    step(1, 0, 'h3FF, 1023);
    for (int i = 0; i < 1045; i++) begin
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL max_rows cycle %0d: got %h required %h", i + 1, act_vec(), exp_vec());
      end
      if (done) dcnt++;
      step(0, 0, 0, 0);
    end
    checks++;
    if (dcnt !== 1) begin
      errors++;
      $display("FAIL max_rows_done: got %0d required 1", dcnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_rows();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
